// File: rtl/ps2_key_sequencer.sv
// PS/2 set-2 key sequencer: pops the ps2_keyboard scan-code FIFO with a
// three-state IDLE/POP/GAP handshake and decodes E0/F0 prefixes into key events.
module ps2_key_sequencer #(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 1000000,
    parameter bit REPEAT_EN   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_ready,
    input  logic             kbd_overflow,
    output logic             kbd_nextdata_n,
    input  logic             clr_cnt,
    input  logic             clr_ovf,
    output logic             evt_valid,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_break,
    output logic             key_down,
    output logic [7:0]       cur_code,
    output logic             cur_ext,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf_sticky
);

    localparam int                TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        POP,
        GAP
    } state_t;

    state_t          r_state;
    logic [7:0]      r_byte;
    logic            r_ext_pend;
    logic            r_brk_pend;
    logic [TO_W-1:0] r_to_cnt;

    logic w_is_e0;
    logic w_is_f0;
    logic w_match;

    assign w_is_e0 = (r_byte == 8'hE0);
    assign w_is_f0 = (r_byte == 8'hF0);
    // Decoded byte refers to the key currently held down.
    assign w_match = key_down && (r_byte == cur_code) && (r_ext_pend == cur_ext);

    assign kbd_nextdata_n = (r_state != POP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_byte     <= '0;
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
            r_to_cnt   <= '0;
            evt_valid  <= 1'b0;
            evt_code   <= '0;
            evt_ext    <= 1'b0;
            evt_break  <= 1'b0;
            key_down   <= 1'b0;
            cur_code   <= '0;
            cur_ext    <= 1'b0;
            press_cnt  <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            evt_valid <= 1'b0;

            if (kbd_overflow) begin
                ovf_sticky <= 1'b1;
            end else if (clr_ovf) begin
                ovf_sticky <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (kbd_ready) begin
                        r_byte   <= kbd_data;
                        r_to_cnt <= '0;
                        r_state  <= POP;
                    end else if (r_ext_pend || r_brk_pend) begin
                        // A prefix left dangling too long is discarded.
                        if (r_to_cnt == TO_LAST) begin
                            r_ext_pend <= 1'b0;
                            r_brk_pend <= 1'b0;
                            r_to_cnt   <= '0;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_W'(1);
                        end
                    end
                end
                POP: begin
                    r_state <= GAP;
                    if (w_is_e0) begin
                        r_ext_pend <= 1'b1;
                    end else if (w_is_f0) begin
                        r_brk_pend <= 1'b1;
                    end else begin
                        r_ext_pend <= 1'b0;
                        r_brk_pend <= 1'b0;
                        if (r_brk_pend) begin
                            evt_valid <= 1'b1;
                            evt_code  <= r_byte;
                            evt_ext   <= r_ext_pend;
                            evt_break <= 1'b1;
                            if (w_match) begin
                                key_down <= 1'b0;
                            end
                        end else if (w_match) begin
                            if (REPEAT_EN) begin
                                evt_valid <= 1'b1;
                                evt_code  <= r_byte;
                                evt_ext   <= r_ext_pend;
                                evt_break <= 1'b0;
                            end
                        end else begin
                            evt_valid <= 1'b1;
                            evt_code  <= r_byte;
                            evt_ext   <= r_ext_pend;
                            evt_break <= 1'b0;
                            key_down  <= 1'b1;
                            cur_code  <= r_byte;
                            cur_ext   <= r_ext_pend;
                            press_cnt <= press_cnt + CNT_W'(1);
                        end
                    end
                end
                GAP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (clr_cnt) begin
                press_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: two instances (repeat dropped / repeat emitted)
// share one FIFO model and are scored per cycle against a key-event model.
module tb_ps2_key_sequencer;

    localparam int CNT_W = 2;
    localparam int TO    = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]       kbd_data;
    logic             kbd_ready;
    logic             kbd_overflow;
    logic             clr_cnt;
    logic             clr_ovf;
    logic             nd         [2];
    logic             evt_valid  [2];
    logic [7:0]       evt_code   [2];
    logic             evt_ext    [2];
    logic             evt_break  [2];
    logic             key_down   [2];
    logic [7:0]       cur_code   [2];
    logic             cur_ext    [2];
    logic [CNT_W-1:0] press_cnt  [2];
    logic             ovf_sticky [2];

    ps2_key_sequencer #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO), .REPEAT_EN(1'b0)) dut_r0 (
        .clk(clk), .rst(rst), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
        .kbd_overflow(kbd_overflow), .kbd_nextdata_n(nd[0]), .clr_cnt(clr_cnt),
        .clr_ovf(clr_ovf), .evt_valid(evt_valid[0]), .evt_code(evt_code[0]),
        .evt_ext(evt_ext[0]), .evt_break(evt_break[0]), .key_down(key_down[0]),
        .cur_code(cur_code[0]), .cur_ext(cur_ext[0]), .press_cnt(press_cnt[0]),
        .ovf_sticky(ovf_sticky[0])
    );

    ps2_key_sequencer #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO), .REPEAT_EN(1'b1)) dut_r1 (
        .clk(clk), .rst(rst), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
        .kbd_overflow(kbd_overflow), .kbd_nextdata_n(nd[1]), .clr_cnt(clr_cnt),
        .clr_ovf(clr_ovf), .evt_valid(evt_valid[1]), .evt_code(evt_code[1]),
        .evt_ext(evt_ext[1]), .evt_break(evt_break[1]), .key_down(key_down[1]),
        .cur_code(cur_code[1]), .cur_ext(cur_ext[1]), .press_cnt(press_cnt[1]),
        .ovf_sticky(ovf_sticky[1])
    );

    logic [7:0] q[$];
    int checks = 0;
    int errors = 0;
    bit popped = 1'b0;
    bit nd_neg = 1'b1, prev_nd = 1'b1, prev2_nd = 1'b1, prev_rdy = 1'b0;
    int ev_seen[2];
    int nd_lows = 0;

    // Key-event model, one slot per instance (slot 1 emits repeats).
    bit         m_ext[2], m_brk[2], m_held[2], m_cext[2], m_emit[2], m_lext[2], m_lbrk[2];
    logic [7:0] m_code[2], m_lcode[2];
    int         m_cnt[2];
    bit         m_ovf;

    function automatic void upd();
        kbd_ready = (q.size() != 0);
        kbd_data  = (q.size() != 0) ? q[0] : 8'h00;
    endfunction

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        upd();
    endtask

    task automatic model_byte(input int d, input logic [7:0] b);
        bit same;
        m_emit[d] = 1'b0;
        if (b == 8'hE0) begin
            m_ext[d] = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk[d] = 1'b1;
        end else begin
            same = m_held[d] && (m_code[d] == b) && (m_cext[d] == m_ext[d]);
            if (m_brk[d] || !same || d == 1) begin
                m_emit[d] = 1'b1;
                m_lcode[d] = b;
                m_lext[d]  = m_ext[d];
                m_lbrk[d]  = m_brk[d];
            end
            if (m_brk[d]) begin
                if (same) m_held[d] = 1'b0;
            end else if (!same) begin
                m_held[d] = 1'b1;
                m_code[d] = b;
                m_cext[d] = m_ext[d];
                m_cnt[d]  = (m_cnt[d] + 1) % (1 << CNT_W);
            end
            m_ext[d] = 1'b0;
            m_brk[d] = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ext[d] = 0; m_brk[d] = 0; m_held[d] = 0; m_cext[d] = 0; m_emit[d] = 0;
            m_lext[d] = 0; m_lbrk[d] = 0; m_code[d] = 0; m_lcode[d] = 0; m_cnt[d] = 0;
        end
        m_ovf  = 0;
        popped = 0;
    endtask

    // One clock: score outputs at the falling edge, then advance FIFO and model after the rising edge.
    task automatic tick();
        logic [7:0] b;
        @(negedge clk);
        if (rst) begin
            prev_nd = 1'b1; prev2_nd = 1'b1; prev_rdy = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (evt_valid[d] !== (popped && m_emit[d])) begin
                    errors++;
                    $display("FAIL evt_valid[%0d] t=%0t: got %b want %b", d, $time, evt_valid[d], popped && m_emit[d]);
                end
                checks++;
                if (evt_code[d] !== m_lcode[d] || evt_ext[d] !== m_lext[d] || evt_break[d] !== m_lbrk[d]) begin
                    errors++;
                    $display("FAIL evt_fields[%0d] t=%0t: got %h/%b/%b want %h/%b/%b", d, $time,
                             evt_code[d], evt_ext[d], evt_break[d], m_lcode[d], m_lext[d], m_lbrk[d]);
                end
                checks++;
                if (key_down[d] !== m_held[d] || cur_code[d] !== m_code[d] || cur_ext[d] !== m_cext[d] ||
                    press_cnt[d] !== CNT_W'(m_cnt[d])) begin
                    errors++;
                    $display("FAIL key_state[%0d] t=%0t: got down=%b code=%h ext=%b cnt=%0d want %b %h %b %0d", d, $time,
                             key_down[d], cur_code[d], cur_ext[d], press_cnt[d], m_held[d], m_code[d], m_cext[d], m_cnt[d]);
                end
                checks++;
                if (ovf_sticky[d] !== m_ovf) begin
                    errors++;
                    $display("FAIL ovf_sticky[%0d] t=%0t: got %b want %b", d, $time, ovf_sticky[d], m_ovf);
                end
                if (evt_valid[d] === 1'b1) ev_seen[d]++;
            end
            checks++;
            if (nd[1] !== nd[0]) begin
                errors++;
                $display("FAIL nextdata_match t=%0t: got %b want %b", $time, nd[1], nd[0]);
            end
            if (nd[0] === 1'b0) begin
                nd_lows++;
                checks++;
                if (!(prev_nd && prev2_nd && prev_rdy)) begin
                    errors++;
                    $display("FAIL handshake t=%0t: got prev_nd=%b prev2_nd=%b prev_ready=%b want 1/1/1",
                             $time, prev_nd, prev2_nd, prev_rdy);
                end
            end
            prev2_nd = prev_nd;
            prev_nd  = nd[0];
            prev_rdy = kbd_ready;
        end
        nd_neg = nd[0];
        @(posedge clk);
        #1;
        popped = 1'b0;
        if (!rst) begin
            if (nd_neg == 1'b0) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_empty t=%0t: got pop want none", $time);
                end else begin
                    b = q.pop_front();
                    upd();
                    model_byte(0, b);
                    model_byte(1, b);
                    popped = 1'b1;
                end
            end
            if (clr_cnt) begin
                m_cnt[0] = 0;
                m_cnt[1] = 0;
            end
            if (kbd_overflow) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d bytes left want 0", q.size());
            q.delete();
            upd();
        end
        repeat (3) tick();
    endtask

    task automatic pulse_clr_cnt();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        for (int d = 0; d < 2; d++) begin
            if ({evt_valid[d], evt_code[d], evt_ext[d], evt_break[d], key_down[d], cur_code[d], cur_ext[d],
                 press_cnt[d], ovf_sticky[d]} !== '0 || nd[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_state[%0d]: got nd=%b valid=%b code=%h down=%b cnt=%0d want nd=1 rest 0",
                         d, nd[d], evt_valid[d], evt_code[d], key_down[d], press_cnt[d]);
            end
        end
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_press_release();
        int e0 = ev_seen[0], e1 = ev_seen[1], nl = nd_lows;
        push(8'h15); push(8'hF0); push(8'h15);
        wait_drain();
        checks++;
        if (ev_seen[0] - e0 != 2 || ev_seen[1] - e1 != 2 || nd_lows - nl != 3) begin
            errors++;
            $display("FAIL press_release: got events %0d/%0d pops %0d want 2/2 pops 3",
                     ev_seen[0] - e0, ev_seen[1] - e1, nd_lows - nl);
        end
        checks++;
        if (key_down[0] !== 1'b0 || press_cnt[0] !== 2'd1 || evt_break[0] !== 1'b1 || evt_code[0] !== 8'h15) begin
            errors++;
            $display("FAIL press_release_state: got down=%b cnt=%0d brk=%b code=%h want 0 1 1 15",
                     key_down[0], press_cnt[0], evt_break[0], evt_code[0]);
        end
    endtask

    task automatic test_extended();
        int e0 = ev_seen[0];
        push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
        wait_drain();
        checks++;
        if (ev_seen[0] - e0 != 2 || evt_code[0] !== 8'h75 || evt_ext[0] !== 1'b1 || evt_break[0] !== 1'b1 ||
            key_down[0] !== 1'b0) begin
            errors++;
            $display("FAIL extended: got events %0d code=%h ext=%b brk=%b down=%b want 2 75 1 1 0",
                     ev_seen[0] - e0, evt_code[0], evt_ext[0], evt_break[0], key_down[0]);
        end
    endtask

    task automatic test_typematic();
        int e0, e1;
        pulse_clr_cnt();
        e0 = ev_seen[0];
        e1 = ev_seen[1];
        push(8'h23); push(8'h23); push(8'h23); push(8'hF0); push(8'h23);
        wait_drain();
        checks++;
        if (ev_seen[0] - e0 != 2 || ev_seen[1] - e1 != 4 || press_cnt[0] !== 2'd1 || press_cnt[1] !== 2'd1) begin
            errors++;
            $display("FAIL typematic: got events %0d/%0d cnt %0d/%0d want 2/4 cnt 1/1",
                     ev_seen[0] - e0, ev_seen[1] - e1, press_cnt[0], press_cnt[1]);
        end
    endtask

    task automatic test_rollover();
        logic [7:0]       codes[4];
        logic [CNT_W-1:0] exp_cnt[4];
        int               n = 0;
        codes   = '{8'h15, 8'h23, 8'h1C, 8'h1B};
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0};
        pulse_clr_cnt();
        for (int i = 0; i < 4; i++) begin
            push(codes[i]);
            wait_drain();
            checks++;
            if (press_cnt[0] !== exp_cnt[i]) begin
                errors++;
                $display("FAIL rollover_cnt[%0d]: got %0d want %0d", i, press_cnt[0], exp_cnt[i]);
            end
        end
        checks++;
        if (cur_code[0] !== 8'h1B || key_down[0] !== 1'b1) begin
            errors++;
            $display("FAIL rollover_cur: got %h/%b want 1b/1", cur_code[0], key_down[0]);
        end
        push(8'h15);
        while (nd[0] !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        wait_drain();
        checks++;
        if (press_cnt[0] !== 2'd0 || cur_code[0] !== 8'h15) begin
            errors++;
            $display("FAIL clr_vs_inc: got cnt=%0d code=%h want 0 15", press_cnt[0], cur_code[0]);
        end
    endtask

    task automatic test_timeout();
        push(8'hF0);
        wait_drain();
        repeat (8) tick();
        push(8'h15);
        wait_drain();
        checks++;
        if (evt_break[0] !== 1'b1 || evt_code[0] !== 8'h15) begin
            errors++;
            $display("FAIL prefix_kept: got brk=%b code=%h want 1 15", evt_break[0], evt_code[0]);
        end
        push(8'hF0);
        wait_drain();
        repeat (20) tick();
        m_ext[0] = 0; m_brk[0] = 0; m_ext[1] = 0; m_brk[1] = 0;
        push(8'h15);
        wait_drain();
        checks++;
        if (evt_break[0] !== 1'b0 || key_down[0] !== 1'b1 || cur_code[0] !== 8'h15) begin
            errors++;
            $display("FAIL prefix_timeout: got brk=%b down=%b code=%h want 0 1 15", evt_break[0], key_down[0], cur_code[0]);
        end
    endtask

    task automatic test_reset_mid_pop();
        int n = 0;
        int e0;
        kbd_overflow = 1'b1;
        tick();
        kbd_overflow = 1'b0;
        push(8'h1C);
        wait_drain();
        push(8'h2B);
        while (nd[0] !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        for (int d = 0; d < 2; d++) begin
            if ({evt_valid[d], evt_code[d], evt_ext[d], evt_break[d], key_down[d], cur_code[d], cur_ext[d],
                 press_cnt[d], ovf_sticky[d]} !== '0 || nd[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid_pop[%0d]: got nd=%b code=%h down=%b cnt=%0d ovf=%b want nd=1 rest 0",
                         d, nd[d], evt_code[d], key_down[d], press_cnt[d], ovf_sticky[d]);
            end
        end
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        e0 = ev_seen[0];
        wait_drain();
        checks++;
        if (ev_seen[0] - e0 != 1 || cur_code[0] !== 8'h2B || press_cnt[0] !== 2'd1) begin
            errors++;
            $display("FAIL reread_after_reset: got events %0d code=%h cnt=%0d want 1 2b 1",
                     ev_seen[0] - e0, cur_code[0], press_cnt[0]);
        end
    endtask

    task automatic test_overflow();
        kbd_overflow = 1'b1;
        clr_ovf      = 1'b1;
        tick();
        kbd_overflow = 1'b0;
        clr_ovf      = 1'b0;
        repeat (2) tick();
        checks++;
        if (ovf_sticky[0] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: got %b want 1", ovf_sticky[0]);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        tick();
        checks++;
        if (ovf_sticky[0] !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b want 0", ovf_sticky[0]);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool[9];
        pool = '{8'h15, 8'h23, 8'h1C, 8'h1B, 8'h75, 8'h15, 8'h23, 8'hE0, 8'hF0};
        repeat (150) begin
            repeat ($urandom_range(1, 3)) push(pool[$urandom_range(0, 8)]);
            clr_cnt      = ($urandom_range(0, 11) == 0);
            kbd_overflow = ($urandom_range(0, 9) == 0);
            clr_ovf      = ($urandom_range(0, 5) == 0);
            tick();
            clr_cnt      = 1'b0;
            kbd_overflow = 1'b0;
            clr_ovf      = 1'b0;
            repeat ($urandom_range(1, 6)) tick();
        end
        push(8'h29);
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        kbd_overflow = 1'b0;
        clr_cnt      = 1'b0;
        clr_ovf      = 1'b0;
        ev_seen[0]   = 0;
        ev_seen[1]   = 0;
        model_reset();
        upd();
        #1;
        test_reset();
        test_press_release();
        test_extended();
        test_typematic();
        test_rollover();
        test_timeout();
        test_reset_mid_pop();
        test_overflow();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
